// File: rtl/kpd_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// State encoding plus small bit-vector utilities used by the sequencer.
package kpd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESENT,
    ST_WAIT_REL
  } kpd_state_e;

  localparam int unsigned KPD_VEC_W = 32;

  function automatic int unsigned kpd_code_w(
    input int unsigned n_keys
  );
    return (n_keys < 2) ? 1 : $clog2(n_keys);
  endfunction

  function automatic logic kpd_is_single(
    input logic [KPD_VEC_W-1:0] v
  );
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  // Position of the set bit; only meaningful when the vector is single.
  function automatic logic [4:0] kpd_col_idx(
    input logic [KPD_VEC_W-1:0] v
  );
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < KPD_VEC_W; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column returns.
module keypad_col_sync #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] i_col,
  output logic [W-1:0] o_col
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_col;
      r_sync <= r_meta;
    end
  end

  assign o_col = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Key matrix sequencer: row scan, press/release debounce, key encode
// and single-shot valid/ready delivery to the calculator FSM.
module keypad_scan_ctrl
  import kpd_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int CODE_W        = kpd_code_w(N_ROWS * N_COLS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCAN_EN,
  input  logic [N_COLS-1:0] COL,
  output logic [N_ROWS-1:0] ROW,
  output logic              KEY_VALID,
  output logic [CODE_W-1:0] KEY_CODE,
  input  logic              KEY_READY
);

  localparam int ROW_W = $clog2(N_ROWS);
  localparam int DW_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
  localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [N_ROWS-1:0] ROW_ONE  = N_ROWS'(1);

  kpd_state_e r_state, w_state_nxt;

  logic [ROW_W-1:0]  r_row, w_row_nxt, w_row_adv;
  logic [DW_W-1:0]   r_dwell, w_dwell_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CODE_W-1:0] r_cand, w_cand_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt;
  logic [CODE_W-1:0] w_hit;
  logic [N_COLS-1:0] w_col_s;
  logic [31:0]       w_col_ext;
  logic              w_dwell_end;
  logic              w_single;
  logic              w_zero;
  logic              w_run;

  keypad_col_sync #(
    .W (N_COLS)
  ) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .i_col (COL),
    .o_col (w_col_s)
  );

  assign w_col_ext   = 32'(w_col_s);
  assign w_single    = kpd_is_single(w_col_ext);
  assign w_zero      = (w_col_s == '0);
  assign w_dwell_end = (r_dwell == DW_LAST);
  assign w_row_adv   = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);

  assign w_hit = CODE_W'(32'(r_row) * 32'(N_COLS)
               + 32'(kpd_col_idx(w_col_ext)));

  assign w_run = (r_state == ST_SCAN)
              || (r_state == ST_DEBOUNCE)
              || (r_state == ST_WAIT_REL);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_code;
    w_dwell_nxt = '0;

    if (w_run && SCAN_EN) begin
      w_dwell_nxt = w_dwell_end ? '0 : r_dwell + DW_W'(1);
    end

    unique case (r_state)
      ST_IDLE: begin
        if (SCAN_EN) begin
          w_state_nxt = ST_SCAN;
          w_row_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (!SCAN_EN) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dwell_end) begin
          if (w_single) begin
            w_state_nxt = ST_DEBOUNCE;
            w_cand_nxt  = w_hit;
            w_cnt_nxt   = '0;
          end else begin
            w_row_nxt = w_row_adv;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (!SCAN_EN) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dwell_end) begin
          if (w_single && (w_hit == r_cand)) begin
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = ST_PRESENT;
              w_code_nxt  = r_cand;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nxt = ST_SCAN;
            w_row_nxt   = w_row_adv;
          end
        end
      end
      ST_PRESENT: begin
        // A dropped enable never cancels an event already presented.
        if (KEY_READY) begin
          w_state_nxt = SCAN_EN ? ST_WAIT_REL : ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_REL: begin
        if (!SCAN_EN) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dwell_end) begin
          if (!w_zero) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_SCAN;
            w_row_nxt   = w_row_adv;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_dwell <= w_dwell_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign ROW       = (r_state == ST_IDLE) ? '0 : (ROW_ONE << r_row);
  assign KEY_VALID = (r_state == ST_PRESENT);
  assign KEY_CODE  = r_code;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural key matrix.
module tb_keypad_scan_ctrl;

  logic       CLK;
  logic       RESET;
  logic       SCAN_EN;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_READY;
  logic [15:0] kp;

  int checks;
  int errors;
  int cyc;

  keypad_scan_ctrl #(
    .N_ROWS         (4),
    .N_COLS         (4),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SCAN_EN   (SCAN_EN),
    .COL       (COL),
    .ROW       (ROW),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .KEY_READY (KEY_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pressed key (r,c) connects row r to column c.
  always_comb begin
    COL = '0;
    for (int r = 0; r < 4; r++) begin
      if (ROW[r]) COL = COL | kp[r*4 +: 4];
    end
  end

  always @(negedge CLK) begin
    checks++;
    if (!$onehot0(ROW)) begin
      errors++;
      $display("FAIL row_onehot: got %b required one-hot or zero", ROW);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task step();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic wait_valid(input int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      step();
      n++;
      if (KEY_VALID) ok = 1'b1;
    end
  endtask

  task automatic wait_row_start(input logic [3:0] oh, output bit ok);
    int n;
    n = 0;
    while (ROW == oh && n < 20) begin step(); n++; end
    n = 0;
    while (ROW != oh && n < 20) begin step(); n++; end
    ok = (ROW == oh);
  endtask

  typedef struct {
    int r;
    int c;
    int code;
  } kv_t;

  kv_t tbl[6];

  initial begin
    int  n;
    int  c0;
    int  bad;
    bit  ok;

    tbl[0] = '{r: 2, c: 1, code: 9};
    tbl[1] = '{r: 0, c: 3, code: 3};
    tbl[2] = '{r: 1, c: 1, code: 5};
    tbl[3] = '{r: 3, c: 0, code: 12};
    tbl[4] = '{r: 3, c: 3, code: 15};
    tbl[5] = '{r: 1, c: 2, code: 6};

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    kp        = '0;
    RESET     = 1'b1;
    SCAN_EN   = 1'b0;
    KEY_READY = 1'b1;

    repeat (3) step();
    check("rst_row", ROW, 0);
    check("rst_valid", KEY_VALID, 0);
    check("rst_code", KEY_CODE, 0);

    RESET   = 1'b0;
    SCAN_EN = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ROW != 4'(1 << ((i / 4) % 4)) || KEY_VALID) bad++;
    end
    check("idle_scan_sequence_bad_cycles", bad, 0);

    // Clean press row2/col1, latency and no auto-repeat.
    kp = 16'(1) << 9;
    wait_row_start(4'b0100, ok);
    check("k9_row2_reached", ok, 1);
    c0 = cyc;
    wait_valid(60, n, ok);
    check("k9_seen", ok, 1);
    check("k9_latency", cyc - (c0 + 3), 13);
    check("k9_code", KEY_CODE, 9);
    step();
    check("k9_pulse_one_cycle", KEY_VALID, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (KEY_VALID || ROW != 4'b0100) bad++;
    end
    check("k9_held_no_repeat", bad, 0);
    kp = '0;
    c0 = cyc;
    n  = 0;
    while (ROW == 4'b0100 && n < 30) begin step(); n++; end
    check("k9_resume_row3", ROW, 4'b1000);
    check("k9_release_delay_ok",
          int'((cyc - c0) >= 11 && (cyc - c0) <= 14), 1);

    // Bounce on the first debounce sample aborts the attempt.
    kp = 16'(1) << 3;
    wait_row_start(4'b0001, ok);
    check("b3_row0_reached", ok, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (KEY_VALID) bad++;
    end
    kp = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (KEY_VALID) bad++;
    end
    check("b3_abort_no_event", bad, 0);
    check("b3_abort_row_adv", ROW, 4'b0010);
    kp = 16'(1) << 3;
    wait_valid(100, n, ok);
    check("b3_retry_seen", ok, 1);
    check("b3_retry_code", KEY_CODE, 3);
    kp = '0;
    repeat (30) step();

    // Consumer stalls for 20 cycles.
    KEY_READY = 1'b0;
    kp = 16'(1) << 5;
    wait_valid(100, n, ok);
    check("k5_seen", ok, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!KEY_VALID || KEY_CODE != 4'd5) bad++;
    end
    check("k5_stall_hold", bad, 0);
    KEY_READY = 1'b1;
    step();
    check("k5_accept_drop", KEY_VALID, 0);
    check("k5_code_kept", KEY_CODE, 5);
    kp = '0;
    repeat (30) step();

    // Two columns in one row are ignored.
    kp = 16'h0030;
    wait_row_start(4'b0010, ok);
    check("mc_row1_reached", ok, 1);
    n = 0;
    while (ROW == 4'b0010 && n < 8) begin step(); n++; end
    check("mc_dwell_len", n, 4);
    check("mc_row_adv", ROW, 4'b0100);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (KEY_VALID) bad++;
    end
    check("mc_no_event", bad, 0);
    kp = '0;
    repeat (10) step();

    // Enable dropped during debounce.
    kp = 16'(1) << 12;
    wait_row_start(4'b1000, ok);
    check("ed_row3_reached", ok, 1);
    repeat (6) step();
    check("ed_in_debounce", ROW, 4'b1000);
    SCAN_EN = 1'b0;
    step();
    check("ed_row_off", ROW, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (KEY_VALID || ROW != 4'b0000) bad++;
    end
    check("ed_idle_quiet", bad, 0);
    kp = '0;
    SCAN_EN = 1'b1;
    step();
    check("ed_restart_row0", ROW, 4'b0001);
    repeat (10) step();

    // Enable dropped while an event is presented.
    KEY_READY = 1'b0;
    kp = 16'(1) << 10;
    wait_valid(100, n, ok);
    check("ep_seen", ok, 1);
    check("ep_code", KEY_CODE, 10);
    SCAN_EN = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!KEY_VALID || KEY_CODE != 4'd10) bad++;
    end
    check("ep_event_kept", bad, 0);
    KEY_READY = 1'b1;
    step();
    check("ep_accept_drop", KEY_VALID, 0);
    check("ep_idle_row", ROW, 0);
    step();
    check("ep_idle_stays", ROW, 0);
    kp = '0;
    SCAN_EN = 1'b1;
    repeat (10) step();

    // Table of single clean presses.
    foreach (tbl[i]) begin
      kp = 16'(1) << (tbl[i].r * 4 + tbl[i].c);
      wait_valid(100, n, ok);
      check($sformatf("tbl%0d_seen", i), ok, 1);
      check($sformatf("tbl%0d_code", i), KEY_CODE, tbl[i].code);
      step();
      check($sformatf("tbl%0d_pulse", i), KEY_VALID, 0);
      kp = '0;
      repeat (30) step();
    end

    // Reset while presenting.
    KEY_READY = 1'b0;
    kp = 16'(1) << 6;
    wait_valid(100, n, ok);
    check("rp_seen", ok, 1);
    check("rp_code", KEY_CODE, 6);
    RESET = 1'b1;
    step();
    check("rp_valid", KEY_VALID, 0);
    check("rp_row", ROW, 0);
    check("rp_code_clr", KEY_CODE, 0);
    RESET   = 1'b0;
    SCAN_EN = 1'b0;
    kp      = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
